alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_seq_core.sv | 38 +++
 rtl/alu_seq.sv | 75 +++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and shift-op decode shared by the ALU files
package alu_seq_pkg;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return op == OP_SLL || op == OP_SRL || op == OP_SRA;
    endfunction
endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: single-cycle logic, add/sub, set-less-than and overflow
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH:0]   cmp;
    assign sum  = a + b;
    assign diff = a - b;
    // one extra bit makes the borrow/sign of the compare land in the MSB
    assign cmp = ctrl == OP_SLT ? {a[WIDTH-1], a} - {b[WIDTH-1], b} : {1'b0, a} - {1'b0, b};
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (ctrl)
            OP_AND:          result = a & b;
            OP_OR:           result = a | b;
            OP_NOR:          result = ~(a | b);
            OP_ADD: begin
                result   = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT, OP_SLTU: result = {{(WIDTH-1){1'b0}}, cmp[WIDTH]};
            default:         result = '0;
        endcase
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ops finish in one cycle, shifts step one bit per cycle
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o
);
    state_t           state, next;
    logic [WIDTH-1:0] acc, core_res, imm, step;
    logic [SHW-1:0]   cnt, amt;
    logic [3:0]       op;
    logic             core_ovf, accept, long_shift;

    alu_seq_core #(.WIDTH(WIDTH)) core (
        .ctrl     (ctrl_i),
        .a        (src1_i),
        .b        (src2_i),
        .result   (core_res),
        .overflow (core_ovf)
    );

    assign accept     = valid_i && state == IDLE;
    assign amt        = src2_i[SHW-1:0];
    assign long_shift = is_shift(ctrl_i) && amt != '0;
    assign imm        = is_shift(ctrl_i) ? src1_i : core_res;
    assign step       = op == OP_SLL ? acc << 1 : op == OP_SRL ? acc >> 1 : {acc[WIDTH-1], acc[WIDTH-1:1]};
    assign ready_o    = state == IDLE;
    assign valid_o    = state == DONE;
    assign result_o   = acc;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else       state <= next;

    always_comb begin
        next = state;
        next = state == IDLE  ? (accept ? (long_shift ? SHIFT : DONE) : IDLE) :
               state == SHIFT ? (cnt == SHW'(1) ? DONE : SHIFT) :
                                (ready_i ? IDLE : DONE);
    end

    // acc doubles as the result register; zero/overflow are only meaningful in DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc        <= '0;
            cnt        <= '0;
            op         <= '0;
            zero_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else if (accept) begin
            op         <= ctrl_i;
            acc        <= long_shift ? src1_i : imm;
            cnt        <= long_shift ? amt : '0;
            zero_o     <= !long_shift && imm == '0;
            overflow_o <= !is_shift(ctrl_i) && core_ovf;
        end else if (state == SHIFT) begin
            acc    <= step;
            cnt    <= cnt - 1'b1;
            zero_o <= cnt == SHW'(1) && step == '0;
        end
    end
endmodule
